// File: rtl/ar0134_pkg.sv
// ar0134_pkg: shared FSM state encoding and AR0134 default geometry
package ar0134_pkg;
  typedef enum logic [1:0] {
    CAP_IDLE         = 2'd0,
    CAP_WAIT_FV_LOW  = 2'd1,
    CAP_WAIT_FV_RISE = 2'd2,
    CAP_CAPTURE      = 2'd3
  } cap_state_t;
  localparam int AR_H_ACTIVE = 1282;
  localparam int AR_V_ACTIVE = 722;
  localparam int AR_H_BLANK  = 368;
endpackage

// File: rtl/ar0134_in_sync.sv
// ar0134_in_sync: two-stage staging of sensor FV/LV/data with edge detection on the staged strobes
module ar0134_in_sync #(
  parameter int DW = 10
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iFV,
  input  logic          iLV,
  input  logic [DW-1:0] iData,
  output logic          oFV,
  output logic          oLV,
  output logic [DW-1:0] oData,
  output logic          oFvRise,
  output logic          oFvFall,
  output logic          oLvFall
);
  logic fv2, lv2;
  // r1 captures the pins, r2 holds the previous r1 strobes for edge detection
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oFV   <= 1'b0;
      oLV   <= 1'b0;
      oData <= '0;
      fv2   <= 1'b0;
      lv2   <= 1'b0;
    end else begin
      oFV   <= iFV;
      oLV   <= iLV;
      oData <= iData;
      fv2   <= oFV;
      lv2   <= oLV;
    end
  end
  assign oFvRise = oFV & ~fv2;
  assign oFvFall = ~oFV & fv2;
  assign oLvFall = ~oLV & lv2;
endmodule

// File: rtl/ar0134_capture_ctrl.sv
// ar0134_capture_ctrl: armed frame capture from the AR0134 parallel port with geometry checking
module ar0134_capture_ctrl
  import ar0134_pkg::*;
#(
  parameter int H_ACTIVE = AR_H_ACTIVE,
  parameter int V_ACTIVE = AR_V_ACTIVE,
  parameter int DW       = 10,
  parameter int HCNT_W   = 11,
  parameter int VCNT_W   = 10
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFV,
  input  logic              iLV,
  input  logic [DW-1:0]     iData,
  input  logic              iArm,
  input  logic              iStop,
  input  logic              iContinuous,
  input  logic              iErrClr,
  output logic              oBusy,
  output logic              oFrameStart,
  output logic              oFrameDone,
  output logic              oPixValid,
  output logic [DW-1:0]     oPixData,
  output logic [HCNT_W-1:0] oPixX,
  output logic [VCNT_W-1:0] oPixY,
  output logic [HCNT_W-1:0] oLineLen,
  output logic [VCNT_W-1:0] oFrameLines,
  output logic              oErrH,
  output logic              oErrV,
  output logic [15:0]       oFrameCnt
);
  localparam logic [1:0] IDLE      = CAP_IDLE;
  localparam logic [1:0] WAIT_LOW  = CAP_WAIT_FV_LOW;
  localparam logic [1:0] WAIT_RISE = CAP_WAIT_FV_RISE;
  localparam logic [1:0] CAPTURE   = CAP_CAPTURE;

  logic          fv1, lv1, fvRise, fvFall, lvFall;
  logic [DW-1:0] data1;
  logic [1:0]    state, nextState;
  logic [HCNT_W-1:0] x, xInc;
  logic [VCNT_W-1:0] y, yInc, yNext;
  logic stopPending, inCap, closeLine, closeFrame, pixel, startFrame, setH, setV;

  ar0134_in_sync #(.DW(DW)) uSync (
    .iClk    (iClk),
    .iRst    (iRst),
    .iFV     (iFV),
    .iLV     (iLV),
    .iData   (iData),
    .oFV     (fv1),
    .oLV     (lv1),
    .oData   (data1),
    .oFvRise (fvRise),
    .oFvFall (fvFall),
    .oLvFall (lvFall)
  );

  assign inCap      = state == CAPTURE;
  assign closeLine  = inCap & lvFall;
  assign closeFrame = inCap & fvFall;
  assign pixel      = inCap & lv1 & fv1;
  assign startFrame = (state == WAIT_RISE) & fvRise & ~iStop;
  assign xInc       = (x == '1) ? x : x + 1'b1;
  assign yInc       = (y == '1) ? y : y + 1'b1;
  assign yNext      = closeLine ? yInc : y;
  assign setH       = closeLine & (x != HCNT_W'(H_ACTIVE));
  assign setV       = closeFrame & (yNext != VCNT_W'(V_ACTIVE));
  assign oBusy      = state != IDLE;

  // next-state: stop beats arm, waiting states abort on stop, capture ends only on FV fall
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      nextState = (iArm & ~iStop) ? WAIT_LOW : IDLE;
      WAIT_LOW:  nextState = iStop ? IDLE : (fv1 ? WAIT_LOW : WAIT_RISE);
      WAIT_RISE: nextState = iStop ? IDLE : (fvRise ? CAPTURE : WAIT_RISE);
      default:   nextState = !closeFrame ? CAPTURE :
                             (stopPending | iStop | ~iContinuous) ? IDLE : WAIT_RISE;
    endcase
  end

  // FSM, pixel/line/frame counters, pixel output register and sticky error flags
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      stopPending <= 1'b0;
      x           <= '0;
      y           <= '0;
      oFrameStart <= 1'b0;
      oFrameDone  <= 1'b0;
      oPixValid   <= 1'b0;
      oPixData    <= '0;
      oPixX       <= '0;
      oPixY       <= '0;
      oLineLen    <= '0;
      oFrameLines <= '0;
      oErrH       <= 1'b0;
      oErrV       <= 1'b0;
      oFrameCnt   <= '0;
    end else begin
      state       <= nextState;
      stopPending <= (state == IDLE) ? 1'b0 : (stopPending | (inCap & iStop));
      oFrameStart <= startFrame;
      oFrameDone  <= closeFrame;
      oPixValid   <= pixel;
      oErrH       <= setH | (oErrH & ~iErrClr);
      oErrV       <= setV | (oErrV & ~iErrClr);
      oFrameCnt   <= oFrameCnt + {15'd0, closeFrame};
      if (pixel) begin
        oPixData <= data1;
        oPixX    <= x;
        oPixY    <= y;
      end
      if (startFrame) begin
        x <= '0;
        y <= '0;
      end else if (closeLine) begin
        oLineLen <= x;
        x        <= '0;
        y        <= yInc;
      end else if (pixel) begin
        x <= xInc;
      end
      if (closeFrame) oFrameLines <= yNext;
    end
  end
endmodule

// File: tb/tb_ar0134_capture_ctrl.sv
// tb_ar0134_capture_ctrl: directed scenarios against a small FV/LV sensor model (8x4, H blank 4, V blank 20)
module tb_ar0134_capture_ctrl;
  logic       clk = 1'b0;
  logic       rst, fv, lv, arm, stop, cont, errClr;
  logic [9:0] data;
  logic       busy, frameStart, frameDone, pixValid, errH, errV;
  logic [9:0] pixData;
  logic [3:0] pixX, lineLen;
  logic [2:0] pixY, frameLines;
  logic [15:0] frameCnt;
  int errors = 0, checks = 0;
  int pixCnt = 0, startCnt = 0, doneCnt = 0;

  ar0134_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DW(10), .HCNT_W(4), .VCNT_W(3)) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iFV         (fv),
    .iLV         (lv),
    .iData       (data),
    .iArm        (arm),
    .iStop       (stop),
    .iContinuous (cont),
    .iErrClr     (errClr),
    .oBusy       (busy),
    .oFrameStart (frameStart),
    .oFrameDone  (frameDone),
    .oPixValid   (pixValid),
    .oPixData    (pixData),
    .oPixX       (pixX),
    .oPixY       (pixY),
    .oLineLen    (lineLen),
    .oFrameLines (frameLines),
    .oErrH       (errH),
    .oErrV       (errV),
    .oFrameCnt   (frameCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pixel data encodes {line, pixel}; every valid pixel must carry matching X/Y
  always @(posedge clk) begin
    #1;
    if (frameStart) startCnt++;
    if (frameDone) doneCnt++;
    if (pixValid) begin
      pixCnt++;
      chk("pixX", 32'(pixX), 32'(pixData[3:0]));
      chk("pixY", 32'(pixY), 32'(pixData[9:4]));
    end
  end

  task automatic clearCounts();
    pixCnt = 0;
    startCnt = 0;
    doneCnt = 0;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendFrame(input int nLines, input int lastLen, input bit fvWithLv);
    fv = 1'b1;
    for (int l = 0; l < nLines; l++) begin
      repeat (4) @(negedge clk);
      for (int p = 0; p < ((l == nLines - 1) ? lastLen : 8); p++) begin
        lv = 1'b1;
        data = {l[5:0], p[3:0]};
        @(negedge clk);
      end
      lv = 1'b0;
      if (fvWithLv && l == nLines - 1) fv = 1'b0;
    end
    if (!fvWithLv) begin
      repeat (4) @(negedge clk);
      fv = 1'b0;
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; lv = 1'b0; arm = 1'b0; stop = 1'b0;
    cont = 1'b0; errClr = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(pixValid), 0);
    chk("rst_cnt", 32'(frameCnt), 0);
    chk("rst_len", 32'(lineLen), 0);
    chk("rst_errs", 32'({errH, errV}), 0);

    // arm and stop together: stop wins
    arm = 1'b1; stop = 1'b1;
    @(negedge clk);
    arm = 1'b0; stop = 1'b0;
    chk("armstop_busy", 32'(busy), 0);

    // 1: single frame armed while FV low
    clearCounts();
    pulseArm();
    chk("t1_busy_armed", 32'(busy), 1);
    sendFrame(4, 8, 1'b0);
    chk("t1_start", startCnt, 1);
    chk("t1_done", doneCnt, 1);
    chk("t1_pix", pixCnt, 32);
    chk("t1_cnt", 32'(frameCnt), 1);
    chk("t1_len", 32'(lineLen), 8);
    chk("t1_lines", 32'(frameLines), 4);
    chk("t1_errs", 32'({errH, errV}), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: arm mid-frame during line 2, first partial frame must be skipped
    clearCounts();
    fork
      sendFrame(4, 8, 1'b0);
      begin
        repeat (30) @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
      end
    join
    chk("t2_pix_partial", pixCnt, 0);
    chk("t2_start_partial", startCnt, 0);
    chk("t2_busy_wait", 32'(busy), 1);
    sendFrame(4, 8, 1'b0);
    chk("t2_pix", pixCnt, 32);
    chk("t2_done", doneCnt, 1);
    chk("t2_cnt", 32'(frameCnt), 2);
    chk("t2_busy", 32'(busy), 0);

    // 3: continuous mode, stop during the second frame
    clearCounts();
    cont = 1'b1;
    pulseArm();
    sendFrame(4, 8, 1'b0);
    chk("t3_busy_between", 32'(busy), 1);
    fork
      sendFrame(4, 8, 1'b0);
      begin
        repeat (20) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
      end
    join
    sendFrame(4, 8, 1'b0);
    chk("t3_start", startCnt, 2);
    chk("t3_done", doneCnt, 2);
    chk("t3_pix", pixCnt, 64);
    chk("t3_cnt", 32'(frameCnt), 4);
    chk("t3_busy", 32'(busy), 0);
    cont = 1'b0;

    // 4: short last line raises oErrH, clear keeps line length
    clearCounts();
    pulseArm();
    sendFrame(4, 7, 1'b0);
    chk("t4_pix", pixCnt, 31);
    chk("t4_errH", 32'(errH), 1);
    chk("t4_errV", 32'(errV), 0);
    chk("t4_len", 32'(lineLen), 7);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    chk("t4_errH_clr", 32'(errH), 0);
    chk("t4_len_kept", 32'(lineLen), 7);
    chk("t4_cnt_kept", 32'(frameCnt), 5);

    // 5: five lines, FV falls with the last LV
    clearCounts();
    pulseArm();
    sendFrame(5, 8, 1'b1);
    chk("t5_lines", 32'(frameLines), 5);
    chk("t5_errV", 32'(errV), 1);
    chk("t5_errH", 32'(errH), 0);
    chk("t5_done", doneCnt, 1);
    chk("t5_pix", pixCnt, 40);
    chk("t5_cnt", 32'(frameCnt), 6);

    // 6: reset mid-line aborts the frame, re-arm captures cleanly
    clearCounts();
    pulseArm();
    fork
      sendFrame(4, 8, 1'b0);
      begin
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_valid", 32'(pixValid), 0);
        chk("t6_cnt", 32'(frameCnt), 0);
        chk("t6_lines", 32'(frameLines), 0);
        chk("t6_errV", 32'(errV), 0);
        clearCounts();
      end
    join
    chk("t6_no_done", doneCnt, 0);
    chk("t6_no_pix", pixCnt, 0);
    pulseArm();
    sendFrame(4, 8, 1'b0);
    chk("t6_re_pix", pixCnt, 32);
    chk("t6_re_done", doneCnt, 1);
    chk("t6_re_cnt", 32'(frameCnt), 1);
    chk("t6_re_lines", 32'(frameLines), 4);
    chk("t6_re_errs", 32'({errH, errV}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
